// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: FETCH -> DECODE -> EXECUTE -> MEM -> WB.
// Optional retired-instruction counter on instret when RETIRE_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            instr_valid,
  input  logic            EQ,
  output logic            instr_req,
  output logic [2:0]      ALUctrl,
  output logic            ALUsrc,
  output logic [1:0]      ImmSrc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            ResultSrc,
  output logic            PCsrc,
  output logic            PC_en,
  output logic            illegal,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB
  } state_t;

  state_t     state_q;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic       alu_src_q, alu_src_d;
  logic [1:0] imm_src_q, imm_src_d;
  logic       beq_q, beq_d, bne_q, bne_d;
  logic       lw_q, lw_d, sw_q, sw_d;
  logic       illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign f7b5              = instr[30];
  assign unused_instr_bits = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

  always_comb begin
    alu_ctrl_d = '0;
    alu_src_d  = 1'b0;
    imm_src_d  = '0;
    beq_d      = 1'b0;
    bne_d      = 1'b0;
    lw_d       = 1'b0;
    sw_d       = 1'b0;
    illegal_d  = 1'b1;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000: begin illegal_d = 1'b0; alu_ctrl_d = f7b5 ? 3'b001 : 3'b000; end
          3'b111: begin illegal_d = 1'b0; alu_ctrl_d = 3'b010; end
          3'b110: begin illegal_d = 1'b0; alu_ctrl_d = 3'b011; end
          3'b010: begin illegal_d = 1'b0; alu_ctrl_d = 3'b101; end
          default: ;
        endcase
      end
      7'b0010011: begin
        alu_src_d = 1'b1;
        case (funct3)
          3'b000: begin illegal_d = 1'b0; alu_ctrl_d = 3'b000; end
          3'b111: begin illegal_d = 1'b0; alu_ctrl_d = 3'b010; end
          3'b110: begin illegal_d = 1'b0; alu_ctrl_d = 3'b011; end
          3'b010: begin illegal_d = 1'b0; alu_ctrl_d = 3'b101; end
          default: alu_src_d = 1'b0;
        endcase
      end
      7'b0000011: if (funct3 == 3'b010) begin
        illegal_d = 1'b0; lw_d = 1'b1; alu_src_d = 1'b1;
      end
      7'b0100011: if (funct3 == 3'b010) begin
        illegal_d = 1'b0; sw_d = 1'b1; alu_src_d = 1'b1; imm_src_d = 2'b01;
      end
      7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) begin
        illegal_d  = 1'b0;
        beq_d      = (funct3 == 3'b000);
        bne_d      = (funct3 == 3'b001);
        alu_ctrl_d = 3'b001;
        imm_src_d  = 2'b10;
      end
      default: ;
    endcase
  end

  // Decode is captured on the accepting FETCH edge, so DECODE-cycle outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      alu_ctrl_q <= '0;
      alu_src_q  <= 1'b0;
      imm_src_q  <= '0;
      beq_q      <= 1'b0;
      bne_q      <= 1'b0;
      lw_q       <= 1'b0;
      sw_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (instr_valid) begin
          alu_ctrl_q <= alu_ctrl_d;
          alu_src_q  <= alu_src_d;
          imm_src_q  <= imm_src_d;
          beq_q      <= beq_d;
          bne_q      <= bne_d;
          lw_q       <= lw_d;
          sw_q       <= sw_d;
          illegal_q  <= illegal_d;
          state_q    <= S_DECODE;
        end
        S_DECODE:  state_q <= illegal_q ? S_FETCH : S_EXECUTE;
        S_EXECUTE: begin
          if (beq_q || bne_q)    state_q <= S_FETCH;
          else if (lw_q || sw_q) state_q <= S_MEM;
          else                   state_q <= S_WB;
        end
        S_MEM:   state_q <= sw_q ? S_FETCH : S_WB;
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    instr_req = 1'b0;
    ALUctrl   = '0;
    ALUsrc    = 1'b0;
    ImmSrc    = '0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    PCsrc     = 1'b0;
    PC_en     = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      if (state_q != S_FETCH) begin
        ALUctrl = alu_ctrl_q;
        ALUsrc  = alu_src_q;
        ImmSrc  = imm_src_q;
      end
      case (state_q)
        S_FETCH:  instr_req = 1'b1;
        S_DECODE: begin
          illegal = illegal_q;
          PC_en   = illegal_q;
        end
        S_EXECUTE: if (beq_q || bne_q) begin
          PC_en = 1'b1;
          PCsrc = (beq_q & EQ) | (bne_q & ~EQ);
        end
        S_MEM: if (sw_q) begin
          MemWrite = 1'b1;
          PC_en    = 1'b1;
        end
        S_WB: begin
          RegWrite  = 1'b1;
          PC_en     = 1'b1;
          ResultSrc = lw_q;
        end
        default: ;
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)                   instret_q <= '0;
    else if (PC_en && !illegal) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected retirements, a monitor checks each PC_en.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        EQ = 1'b0;
  logic        instr_req;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite, MemWrite, ResultSrc, PCsrc, PC_en, illegal;
  logic [31:0] instret;

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .EQ(EQ),
    .instr_req(instr_req), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .PCsrc(PCsrc), .PC_en(PC_en), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;
    logic        pcsrc, regw, memw, ressrc, ill;
    logic [2:0]  alu;
    logic        alusrc;
    logic [1:0]  imm;
    logic        chk_alu, chk_imm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int unsigned exp_ret = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int unsigned lat, input logic pcsrc, input logic regw,
                              input logic memw, input logic ressrc, input logic ill,
                              input logic [2:0] alu, input logic alusrc, input logic [1:0] imm,
                              input logic chk_alu, input logic chk_imm);
    exp_t r;
    r.lat = lat; r.pcsrc = pcsrc; r.regw = regw; r.memw = memw; r.ressrc = ressrc;
    r.ill = ill; r.alu = alu; r.alusrc = alusrc; r.imm = imm;
    r.chk_alu = chk_alu; r.chk_imm = chk_imm;
    return r;
  endfunction

  // Monitor: pops one expectation per retirement strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_req && instr_valid) acc_cyc = cyc;
      if ((RegWrite || MemWrite) && !PC_en) begin
        checks++; failures++;
        $display("FAIL stray_strobe RegWrite=%0b MemWrite=%0b expected=0 outside retirement", RegWrite, MemWrite);
      end
      if (PC_en) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_retire PC_en=1 expected=0 (no instruction outstanding)");
        end else begin
          e = sb.pop_front();
          chk("latency",   cyc - acc_cyc + 1, e.lat);
          chk("PCsrc",     PCsrc,     e.pcsrc);
          chk("RegWrite",  RegWrite,  e.regw);
          chk("MemWrite",  MemWrite,  e.memw);
          chk("ResultSrc", ResultSrc, e.ressrc);
          chk("illegal",   illegal,   e.ill);
          chk("reg_mem_exclusive", RegWrite & MemWrite, 0);
          if (e.chk_alu) begin
            chk("ALUctrl", ALUctrl, e.alu);
            chk("ALUsrc",  ALUsrc,  e.alusrc);
          end
          if (e.chk_imm) chk("ImmSrc", ImmSrc, e.imm);
          if (!e.ill) exp_ret++;
        end
      end
    end
  end

  task automatic check_instret(input string name);
`ifdef RETIRE_CNT_EN
    chk(name, instret, exp_ret);
`else
    chk(name, instret, 0);
`endif
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (instr_req) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL fetch_timeout instr_req=%0b expected=1", instr_req);
    end
  endtask

  task automatic issue(input logic [31:0] word, input logic eq, input int unsigned waits, input exp_t x);
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    sb.push_back(x);
    EQ = eq;
    for (int unsigned i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      chk("wait_instr_req", instr_req, 1);
      @(posedge clk); #1;
    end
    instr = word; instr_valid = 1'b1;
    @(posedge clk); #1;
    // Strobe outside FETCH with a legal beq word: must be ignored.
    instr = 32'h00000463; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = '0; instr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL retire_timeout outstanding=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {instr_req, ALUctrl, ALUsrc, ImmSrc, RegWrite, MemWrite, ResultSrc,
                          PCsrc, PC_en, illegal}, 0);
    chk("reset_instret", instret, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch_req", instr_req, 1);
    @(posedge clk); #1;

    //          word           EQ  wait  lat pcs rw mw rs ill alu    src imm    ca  ci
    issue(32'h003100B3, 1'b0, 0, mk(4, 0, 1, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0)); // add
    issue(32'h403100B3, 1'b0, 0, mk(4, 0, 1, 0, 0, 0, 3'b001, 0, 2'b00, 1, 0)); // sub
    issue(32'h003120B3, 1'b0, 0, mk(4, 0, 1, 0, 0, 0, 3'b101, 0, 2'b00, 1, 0)); // slt
    issue(32'h00516093, 1'b0, 0, mk(4, 0, 1, 0, 0, 0, 3'b011, 1, 2'b00, 1, 1)); // ori
    issue(32'h00000463, 1'b1, 0, mk(3, 1, 0, 0, 0, 0, 3'b001, 0, 2'b10, 1, 1)); // beq taken
    issue(32'h00000463, 1'b0, 0, mk(3, 0, 0, 0, 0, 0, 3'b001, 0, 2'b10, 1, 1)); // beq not taken
    issue(32'h00001463, 1'b1, 0, mk(3, 0, 0, 0, 0, 0, 3'b001, 0, 2'b10, 1, 1)); // bne EQ=1
    issue(32'h00001463, 1'b0, 0, mk(3, 1, 0, 0, 0, 0, 3'b001, 0, 2'b10, 1, 1)); // bne EQ=0
    issue(32'h00402283, 1'b0, 0, mk(5, 0, 1, 0, 1, 0, 3'b000, 1, 2'b00, 1, 1)); // lw
    issue(32'h00502223, 1'b0, 0, mk(4, 0, 0, 1, 0, 0, 3'b000, 1, 2'b01, 1, 1)); // sw
    issue(32'hFFFFFFFF, 1'b0, 3, mk(2, 0, 0, 0, 0, 1, 3'b000, 0, 2'b00, 0, 0)); // illegal after wait
    issue(32'h00002463, 1'b0, 0, mk(2, 0, 0, 0, 0, 1, 3'b000, 0, 2'b00, 0, 0)); // branch f3=010
    issue(32'h00400283, 1'b0, 0, mk(2, 0, 0, 0, 0, 1, 3'b000, 0, 2'b00, 0, 0)); // lb unsupported
    check_instret("instret_after_mix");

    // Reset during EXECUTE of lw: instruction must be abandoned.
    wait_fetch(ok);
    instr = 32'h00402283; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = '0; instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("lw_exec_alusrc", ALUsrc, 1);
    rst = 1'b1; exp_ret = 0;
    @(negedge clk);
    chk("abort_outputs_zero", {instr_req, ALUctrl, ALUsrc, ImmSrc, RegWrite, MemWrite, ResultSrc,
                               PCsrc, PC_en, illegal}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_fetch_req", instr_req, 1);
    repeat (6) @(posedge clk);
    #1;
    check_instret("instret_after_abort");

    for (int i = 0; i < 3; i++)
      issue(32'h003100B3, 1'b0, 0, mk(4, 0, 1, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0));
    check_instret("instret_three_adds");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
